mod_seg7_scanner: RTL and testbench

//  Parametrised multiplexed 7-segment display driver: N hex digits with per-digit

---
 rtl/mod_seg7_scanner_pkg.sv | 40 ++++
 rtl/mod_seg7_scanner_hex7seg.sv | 41 ++++
 rtl/mod_seg7_scanner.sv | 150 +++++++++++++++
 tb/tb_mod_seg7_scanner.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_seg7_scanner_pkg.sv
// ============================================================================
// Module      : mod_seg7_scanner_pkg
// Description : Shared types and active-low segment codes (g..a) for the
//               multiplexed 7-segment scanner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mod_seg7_scanner_pkg;

    typedef logic [6:0] seg7_t;
    typedef logic [3:0] hex_t;

    // All segments off (active-low)
    localparam seg7_t c_SEG_BLANK = 7'h7F;

    // Hex glyphs, bit 6 = g ... bit 0 = a, 0 = segment lit
    localparam seg7_t c_SEG_0 = 7'h40;
    localparam seg7_t c_SEG_1 = 7'h79;
    localparam seg7_t c_SEG_2 = 7'h24;
    localparam seg7_t c_SEG_3 = 7'h30;
    localparam seg7_t c_SEG_4 = 7'h19;
    localparam seg7_t c_SEG_5 = 7'h12;
    localparam seg7_t c_SEG_6 = 7'h02;
    localparam seg7_t c_SEG_7 = 7'h58;
    localparam seg7_t c_SEG_8 = 7'h00;
    localparam seg7_t c_SEG_9 = 7'h10;
    localparam seg7_t c_SEG_A = 7'h08;
    localparam seg7_t c_SEG_B = 7'h03;
    localparam seg7_t c_SEG_C = 7'h27;
    localparam seg7_t c_SEG_D = 7'h21;
    localparam seg7_t c_SEG_E = 7'h06;
    localparam seg7_t c_SEG_F = 7'h0E;

    // Brightness field width; compared against the prescaler's top bits
    localparam int c_BRIGHT_W = 4;

endpackage : mod_seg7_scanner_pkg

`default_nettype wire

// File: rtl/mod_seg7_scanner_hex7seg.sv
// ============================================================================
// Module      : mod_hex7seg
// Description : Combinational 4-bit hex value to active-low 7-segment glyph.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_hex7seg
    import mod_seg7_scanner_pkg::*;
(
    input  logic [3:0] i_val,
    output logic [6:0] o_seg
);

    // Glyph lookup for the digit currently being scanned
    always_comb begin
        o_seg = c_SEG_BLANK;
        case (i_val)
            4'h0: o_seg = c_SEG_0;
            4'h1: o_seg = c_SEG_1;
            4'h2: o_seg = c_SEG_2;
            4'h3: o_seg = c_SEG_3;
            4'h4: o_seg = c_SEG_4;
            4'h5: o_seg = c_SEG_5;
            4'h6: o_seg = c_SEG_6;
            4'h7: o_seg = c_SEG_7;
            4'h8: o_seg = c_SEG_8;
            4'h9: o_seg = c_SEG_9;
            4'hA: o_seg = c_SEG_A;
            4'hB: o_seg = c_SEG_B;
            4'hC: o_seg = c_SEG_C;
            4'hD: o_seg = c_SEG_D;
            4'hE: o_seg = c_SEG_E;
            4'hF: o_seg = c_SEG_F;
            default: o_seg = c_SEG_BLANK;
        endcase
    end

endmodule : mod_hex7seg

`default_nettype wire

// File: rtl/mod_seg7_scanner.sv
// ============================================================================
// Module      : mod_seg7_scanner
// Description : Multiplexed common-anode 7-segment driver. N hex digits with
//               per-digit decimal point and blanking, leading-zero
//               suppression and 16-level PWM brightness. Scan rate comes from
//               a free-running prescaler; all outputs registered, active-low.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_seg7_scanner
    import mod_seg7_scanner_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int PRESC_W    = 15
) (
    input  logic                    i_clk,
    input  logic                    i_nRst,
    input  logic [4*NUM_DIGITS-1:0] i_digits,
    input  logic [NUM_DIGITS-1:0]   i_dp,
    input  logic [NUM_DIGITS-1:0]   i_blank,
    input  logic                    i_load,
    input  logic                    i_lz_suppress,
    input  logic [c_BRIGHT_W-1:0]   i_bright,
    output logic [6:0]              o_seg7,
    output logic                    o_dp_n,
    output logic [NUM_DIGITS-1:0]   o_seg7_nSel
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0]   c_IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRESC_W-1:0] c_PRESC_MAX = '1;

    // Scan state
    logic [PRESC_W-1:0]      r_presc;
    logic [IDX_W-1:0]        r_idx;

    // Shadow copies: the display reads only these, so a load never tears
    logic [4*NUM_DIGITS-1:0] r_sh_digits;
    logic [NUM_DIGITS-1:0]   r_sh_dp;
    logic [NUM_DIGITS-1:0]   r_sh_blank;

    // Output registers
    logic [6:0]              r_seg7;
    logic                    r_dp_n;
    logic [NUM_DIGITS-1:0]   r_nsel;

    // Current-digit datapath
    logic [NUM_DIGITS-1:0]   w_lz_mask;
    logic [3:0]              w_cur_val;
    logic                    w_cur_dp;
    logic                    w_cur_dark;
    logic [NUM_DIGITS-1:0]   w_sel_n;
    logic [6:0]              w_cur_seg;
    logic                    w_active;

    // Free-running prescaler; its wrap marks the end of a digit slot
    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PRESC_W'(1);
        end
    end

    // Digit index advances on prescaler wrap and wraps at the last digit
    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            r_idx <= '0;
        end else if (r_presc == c_PRESC_MAX) begin
            r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + IDX_W'(1);
        end
    end

    // Capture digits, decimal points and blanking together on load
    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            r_sh_digits <= '0;
            r_sh_dp     <= '0;
            r_sh_blank  <= '0;
        end else if (i_load) begin
            r_sh_digits <= i_digits;
            r_sh_dp     <= i_dp;
            r_sh_blank  <= i_blank;
        end
    end

    // Leading-zero mask: walk down from the MSD while digits are 0 with no dp
    always_comb begin : p_lz_mask
        logic v_run;
        v_run     = 1'b1;
        w_lz_mask = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            v_run        = v_run & (r_sh_digits[4*k +: 4] == 4'h0) & ~r_sh_dp[k];
            w_lz_mask[k] = i_lz_suppress & v_run;
        end
    end

    // Select the digit under the scan index (single shared decoder downstream)
    always_comb begin
        w_cur_val  = 4'h0;
        w_cur_dp   = 1'b0;
        w_cur_dark = 1'b1;
        w_sel_n    = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_cur_val  = r_sh_digits[4*k +: 4];
                w_cur_dp   = r_sh_dp[k];
                w_cur_dark = r_sh_blank[k] | w_lz_mask[k];
                w_sel_n[k] = 1'b0;
            end
        end
    end

    mod_hex7seg u_hex7seg (
        .i_val (w_cur_val),
        .o_seg (w_cur_seg)
    );

    // Lit window: skip p==0 dead time, PWM against brightness, honour blanking
    always_comb begin
        w_active = (r_presc != '0)
                && (r_presc[PRESC_W-1 -: c_BRIGHT_W] <= i_bright)
                && !w_cur_dark;
    end

    // Register select, segments and dp together so they change in one cycle
    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            r_nsel <= '1;
            r_seg7 <= c_SEG_BLANK;
            r_dp_n <= 1'b1;
        end else if (w_active) begin
            r_nsel <= w_sel_n;
            r_seg7 <= w_cur_seg;
            r_dp_n <= ~w_cur_dp;
        end else begin
            r_nsel <= '1;
            r_seg7 <= c_SEG_BLANK;
            r_dp_n <= 1'b1;
        end
    end

    assign o_seg7      = r_seg7;
    assign o_dp_n      = r_dp_n;
    assign o_seg7_nSel = r_nsel;

endmodule : mod_seg7_scanner

`default_nettype wire

// File: tb/tb_mod_seg7_scanner.sv
// ============================================================================
// Module      : tb_mod_seg7_scanner
// Description : Self-checking bench for mod_seg7_scanner (4 digits, 16-clock
//               slots) with a cycle-count reference model and literal pins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mod_seg7_scanner;

    localparam int ND   = 4;
    localparam int PW   = 4;
    localparam int SLOT = 1 << PW;
    localparam int FRAME = SLOT * ND;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [15:0]   digits = 16'h0;
    logic [3:0]    dp = 4'h0;
    logic [3:0]    blank = 4'h0;
    logic          load = 1'b0;
    logic          lz = 1'b0;
    logic [3:0]    bright = 4'hF;
    logic [6:0]    seg7;
    logic          dp_n;
    logic [3:0]    nsel;

    int n_vec = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    mod_seg7_scanner #(
        .NUM_DIGITS (ND),
        .PRESC_W    (PW)
    ) dut (
        .i_clk         (clk),
        .i_nRst        (rst_n),
        .i_digits      (digits),
        .i_dp          (dp),
        .i_blank       (blank),
        .i_load        (load),
        .i_lz_suppress (lz),
        .i_bright      (bright),
        .o_seg7        (seg7),
        .o_dp_n        (dp_n),
        .o_seg7_nSel   (nsel)
    );

    always #5 clk = ~clk;

    // Reference glyph table
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h58,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};

    // Expected {nSel, seg, dp_n} for the display state at clock count cyc
    function automatic logic [11:0] model_out(input int cyc, input logic [15:0] dg,
                                              input logic [3:0] dpv, input logic [3:0] bl,
                                              input logic lzv, input logic [3:0] br);
        int  p;
        int  k;
        int  lvl;
        bit  supp;
        logic [3:0] v;
        p    = cyc % SLOT;
        k    = (cyc / SLOT) % ND;
        lvl  = p >> (PW - 4);
        v    = dg[4*k +: 4];
        supp = lzv && (k > 0) && ((dg >> (4*k)) == 16'h0) && ((dpv >> k) == 4'h0);
        if (p != 0 && lvl <= int'(br) && !bl[k] && !supp)
            return {~(4'b0001 << k), seg_tab[v], ~dpv[k]};
        return {4'hF, 7'h7F, 1'b1};
    endfunction

    // Model state: clocks since reset plus the loaded display image
    int         m_cyc = 0;
    logic [15:0] m_dig = 16'h0;
    logic [3:0]  m_dp = 4'h0;
    logic [3:0]  m_bl = 4'h0;
    logic [3:0]  e_nsel = 4'hF;
    logic [6:0]  e_seg = 7'h7F;
    logic        e_dp_n = 1'b1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc  <= 0;
            m_dig  <= 16'h0;
            m_dp   <= 4'h0;
            m_bl   <= 4'h0;
            e_nsel <= 4'hF;
            e_seg  <= 7'h7F;
            e_dp_n <= 1'b1;
        end else begin
            {e_nsel, e_seg, e_dp_n} <= model_out(m_cyc, m_dig, m_dp, m_bl, lz, bright);
            m_cyc <= m_cyc + 1;
            if (load) begin
                m_dig <= digits;
                m_dp  <= dp;
                m_bl  <= blank;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            n_vec = n_vec + 1;
            if (nsel !== e_nsel || seg7 !== e_seg || dp_n !== e_dp_n) begin
                n_err = n_err + 1;
                $display("FAIL scan cyc=%0d: got nSel=%h seg=%h dp_n=%b, expected nSel=%h seg=%h dp_n=%b",
                         m_cyc, nsel, seg7, dp_n, e_nsel, e_seg, e_dp_n);
            end
        end
    end

    task automatic check_lit(input string nm, input logic [3:0] en, input logic [6:0] es,
                             input logic ed);
        n_vec = n_vec + 1;
        if (nsel !== en || seg7 !== es || dp_n !== ed) begin
            n_err = n_err + 1;
            $display("FAIL %s: got nSel=%h seg=%h dp_n=%b, expected nSel=%h seg=%h dp_n=%b",
                     nm, nsel, seg7, dp_n, en, es, ed);
        end
    endtask

    // Advance to the negedge where outputs show slot idx at prescaler value p
    task automatic goto_slot(input int idx, input int p);
        int guard;
        guard = 0;
        @(negedge clk);
        while ((m_cyc % FRAME) != ((idx * SLOT + p + 1) % FRAME) && guard < 4 * FRAME) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 4 * FRAME) begin
            n_vec = n_vec + 1;
            n_err = n_err + 1;
            $display("FAIL goto_slot: timeout waiting for slot %0d p=%0d", idx, p);
        end
    endtask

    task automatic pulse_load();
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int cnt;
        digits = 16'h12AF;
        load   = 1'b1;
        bright = 4'hF;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check_lit("reset_state", 4'hF, 7'h7F, 1'b1);

        // Release; load is held so the shadow fills on clk 1
        rst_n = 1'b1;
        @(negedge clk);
        check_lit("clk1_dead", 4'hF, 7'h7F, 1'b1);
        @(negedge clk);
        check_lit("clk2_first_sel", 4'hE, 7'h0E, 1'b1);
        load = 1'b0;

        // Full brightness: 15 lit clocks then one dead clock per slot
        cnt = (nsel != 4'hF) ? 1 : 0;
        repeat (15) begin
            @(negedge clk);
            if (nsel != 4'hF) cnt++;
        end
        n_vec = n_vec + 1;
        if (cnt != 15) begin
            n_err = n_err + 1;
            $display("FAIL duty_bright15: got %0d lit clocks, expected 15", cnt);
        end

        goto_slot(1, 1);  check_lit("digit1_A",   4'hD, 7'h08, 1'b1);
        goto_slot(2, 1);  check_lit("digit2_2",   4'hB, 7'h24, 1'b1);
        goto_slot(3, 1);  check_lit("digit3_1",   4'h7, 7'h79, 1'b1);
        goto_slot(0, 0);  check_lit("dead_time",  4'hF, 7'h7F, 1'b1);

        // New digits without load must not reach the display
        digits = 16'h3456;
        goto_slot(0, 5);  check_lit("no_load_hold", 4'hE, 7'h0E, 1'b1);
        pulse_load();
        goto_slot(1, 2);  check_lit("loaded_d1", 4'hD, 7'h12, 1'b1);
        goto_slot(2, 2);  check_lit("loaded_d2", 4'hB, 7'h19, 1'b1);
        goto_slot(3, 2);  check_lit("loaded_d3", 4'h7, 7'h30, 1'b1);

        // Leading-zero suppression
        digits = 16'h0045;
        lz     = 1'b1;
        pulse_load();
        goto_slot(3, 5);  check_lit("lz_d3_dark", 4'hF, 7'h7F, 1'b1);
        goto_slot(2, 5);  check_lit("lz_d2_dark", 4'hF, 7'h7F, 1'b1);
        goto_slot(1, 5);  check_lit("lz_d1_4",    4'hD, 7'h19, 1'b1);
        goto_slot(0, 5);  check_lit("lz_d0_5",    4'hE, 7'h12, 1'b1);
        digits = 16'h0000;
        pulse_load();
        goto_slot(0, 5);  check_lit("lz_zero_d0", 4'hE, 7'h40, 1'b1);
        goto_slot(1, 5);  check_lit("lz_zero_d1", 4'hF, 7'h7F, 1'b1);

        // Brightness PWM
        digits = 16'h12AF;
        lz     = 1'b0;
        bright = 4'd3;
        pulse_load();
        goto_slot(0, 3);  check_lit("bright3_p3", 4'hE, 7'h0E, 1'b1);
        goto_slot(0, 4);  check_lit("bright3_p4", 4'hF, 7'h7F, 1'b1);
        bright = 4'd0;
        goto_slot(1, 1);  check_lit("bright0_p1", 4'hF, 7'h7F, 1'b1);

        // A lit decimal point stops suppression
        bright = 4'hF;
        digits = 16'h0005;
        dp     = 4'b0010;
        lz     = 1'b1;
        pulse_load();
        goto_slot(1, 5);  check_lit("dp_keeps_d1", 4'hD, 7'h40, 1'b0);
        goto_slot(2, 5);  check_lit("dp_d2_dark",  4'hF, 7'h7F, 1'b1);
        goto_slot(0, 5);  check_lit("dp_d0",       4'hE, 7'h12, 1'b1);

        // Explicit blanking
        blank = 4'b0001;
        pulse_load();
        goto_slot(0, 5);  check_lit("blank_d0", 4'hF, 7'h7F, 1'b1);
        goto_slot(1, 5);  check_lit("blank_d1", 4'hD, 7'h40, 1'b0);

        // Mid-slot asynchronous reset at digit 2
        blank  = 4'h0;
        dp     = 4'h0;
        lz     = 1'b0;
        digits = 16'h12AF;
        pulse_load();
        goto_slot(2, 7);  check_lit("pre_reset_d2", 4'hB, 7'h24, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_lit("async_reset_dark", 4'hF, 7'h7F, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_lit("post_reset_clk1", 4'hF, 7'h7F, 1'b1);
        @(negedge clk);
        check_lit("post_reset_d0", 4'hE, 7'h40, 1'b1);
        repeat (FRAME) @(negedge clk);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mod_seg7_scanner

`default_nettype wire
